// File: rtl/uart_src_arb.sv
// rtl/uart_src_arb.sv - two-source UART byte arbiter with per-source FIFOs
//
// Purpose: buffers bytes from two uart_rx sources (src0 = HC-01, src1 = BLE)
// in small FIFOs and grants one source per command frame to a single
// consumer over a valid/ready handshake. A frame ends when EOF_BYTE is
// loaded into the output register, or is aborted after TO_CYC idle cycles.
//
// Ports:
//   clk, rst_n            system clock, synchronous active-low reset
//   s0_data/s0_valid      src0 byte + one-cycle strobe
//   s1_data/s1_valid      src1 byte + one-cycle strobe
//   out_data/out_valid    granted byte, held until out_ready
//   out_ready             consumer accept
//   out_src               source of out_data
//   out_abort             one-cycle pulse on frame timeout
//   ovf_clr               clears the sticky overflow flags
//   s0_ovf/s1_ovf         sticky: a byte was dropped on a full FIFO
//
// Build option: define ARB_FIXED_PRIO_EN to make src0 always win in IDLE
// when both FIFOs hold data (default: round-robin on last_grant).

module uart_src_arb #(
  parameter int unsigned CLK_FRE    = 50,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter logic [7:0]  EOF_BYTE   = 8'h0A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_src,
  output logic       out_abort,
  input  logic       ovf_clr,
  output logic       s0_ovf,
  output logic       s1_ovf
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned TO_CYC = CLK_FRE * TIMEOUT_US;
  localparam int unsigned TW     = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYC - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_e;

  state_e          state_q;
  logic [7:0]      mem_q    [2][FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q [2];
  logic [AW-1:0]   rd_ptr_q [2];
  logic [CW-1:0]   cnt_q    [2];
  logic [1:0]      ovf_q;
  logic            last_grant_q;
  logic [TW-1:0]   to_cnt_q;
  logic [7:0]      out_data_q;
  logic            out_valid_q;
  logic            out_src_q;
  logic            out_abort_q;

  logic [1:0]      in_valid, nonempty, full, pop, push, drop;
  logic [7:0]      in_data [2];
  logic            sel, locked, load, eof_load, pick1;
  logic [7:0]      head;

  assign in_valid   = {s1_valid, s0_valid};
  assign in_data[0] = s0_data;
  assign in_data[1] = s1_data;

  always_comb begin
    nonempty = '0;
    full     = '0;
    for (int i = 0; i < 2; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
      full[i]     = (cnt_q[i] == FULL_CNT);
    end
  end

  assign sel      = (state_q == LOCK1);
  assign locked   = (state_q != IDLE);
  assign head     = mem_q[sel][rd_ptr_q[sel]];
  assign load     = locked && nonempty[sel] && (!out_valid_q || out_ready);
  assign eof_load = load && (head == EOF_BYTE);
  assign pop      = {load && sel, load && !sel};
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push     = in_valid & (~full | pop);
  assign drop     = in_valid & full & ~pop;

`ifdef ARB_FIXED_PRIO_EN
  assign pick1 = !nonempty[0];
`else
  // src1 wins if it is the only one waiting, or both wait and src0 went last.
  assign pick1 = nonempty[1] && (!nonempty[0] || !last_grant_q);
`endif

  // Storage is not reset; emptiness is carried by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      to_cnt_q     <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_src_q    <= 1'b0;
      out_abort_q  <= 1'b0;
      ovf_q        <= '0;
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + 1'b1;
          2'b01:   cnt_q[i] <= cnt_q[i] - 1'b1;
          default: ;
        endcase
        if (drop[i])     ovf_q[i] <= 1'b1;
        else if (ovf_clr) ovf_q[i] <= 1'b0;
      end

      out_abort_q <= 1'b0;
      if (load) begin
        out_data_q  <= head;
        out_valid_q <= 1'b1;
        out_src_q   <= sel;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          if (|nonempty) state_q <= pick1 ? LOCK1 : LOCK0;
        end
        default: begin
          if (load) begin
            to_cnt_q <= '0;
            // EOF closes the frame on the same edge it is loaded.
            if (eof_load) begin
              last_grant_q <= sel;
              state_q      <= IDLE;
            end
          end else if (!nonempty[sel]) begin
            if (to_cnt_q == TO_LAST) begin
              out_abort_q  <= 1'b1;
              last_grant_q <= sel;
              state_q      <= IDLE;
              to_cnt_q     <= '0;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign out_abort = out_abort_q;
  assign s0_ovf    = ovf_q[0];
  assign s1_ovf    = ovf_q[1];

endmodule

// File: tb/tb_uart_src_arb.sv
// tb/tb_uart_src_arb.sv - self-checking bench for uart_src_arb
module tb_uart_src_arb;

  localparam int TO_CYC = 50;
  localparam int DEPTH  = 4;
  localparam logic [7:0] EOF = 8'h0A;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s0_data = '0, s1_data = '0;
  logic       s0_valid = 1'b0, s1_valid = 1'b0;
  logic       out_ready = 1'b1, ovf_clr = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_src, out_abort, s0_ovf, s1_ovf;

  int compared = 0;
  int mismatched = 0;

  uart_src_arb #(
    .CLK_FRE(50), .FIFO_DEPTH(DEPTH), .TIMEOUT_US(1), .EOF_BYTE(EOF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_data(s0_data), .s0_valid(s0_valid),
    .s1_data(s1_data), .s1_valid(s1_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .out_abort(out_abort), .ovf_clr(ovf_clr),
    .s0_ovf(s0_ovf), .s1_ovf(s1_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: byte queues per source, granted source (-1 = none).
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  int         mg;
  int         mgap;
  logic       mlast, mv, ms, mab, mov0, mov1;
  logic [7:0] md, mb;
  logic       mld;

  function automatic int qsize(int n);
    return (n == 1) ? mq1.size() : mq0.size();
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq0.delete(); mq1.delete();
      mg = -1; mgap = 0; mlast = 1'b1; mv = 1'b0; ms = 1'b0; md = '0;
      mab = 1'b0; mov0 = 1'b0; mov1 = 1'b0;
    end else begin
      mab = 1'b0;
      mld = 1'b0;
      if (mg < 0) begin
        if (mq0.size() > 0 && mq1.size() > 0) begin
`ifdef ARB_FIXED_PRIO_EN
          mg = 0;
`else
          mg = mlast ? 0 : 1;
`endif
        end else if (mq0.size() > 0) mg = 0;
        else if (mq1.size() > 0) mg = 1;
        mgap = 0;
      end else if (qsize(mg) > 0 && (!mv || out_ready)) begin
        mb = (mg == 1) ? mq1.pop_front() : mq0.pop_front();
        mld = 1'b1; md = mb; ms = (mg == 1); mgap = 0;
        if (mb == EOF) begin mlast = (mg == 1); mg = -1; end
      end else if (qsize(mg) == 0) begin
        if (mgap == TO_CYC - 1) begin
          mab = 1'b1; mlast = (mg == 1); mg = -1; mgap = 0;
        end else mgap++;
      end
      if (mld) mv = 1'b1; else if (out_ready) mv = 1'b0;
      // Pops are already applied, so "size < DEPTH" covers the same-cycle pop case.
      if (s0_valid && mq0.size() >= DEPTH) mov0 = 1'b1;
      else begin
        if (s0_valid) mq0.push_back(s0_data);
        if (ovf_clr) mov0 = 1'b0;
      end
      if (s1_valid && mq1.size() >= DEPTH) mov1 = 1'b1;
      else begin
        if (s1_valid) mq1.push_back(s1_data);
        if (ovf_clr) mov1 = 1'b0;
      end
    end
  end

  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_valid", out_valid, mv);
      check("m_data", out_data, md);
      check("m_src", out_src, ms);
      check("m_abort", out_abort, mab);
      check("m_ovf0", s0_ovf, mov0);
      check("m_ovf1", s1_ovf, mov1);
    end
  end

  logic [8:0] got[$];
  logic [8:0] exp[$];
  logic       rec = 1'b0;

  task automatic step(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    s0_valid = v0; s0_data = d0; s1_valid = v1; s1_data = d1;
    @(negedge clk);
    if (rec && out_valid) got.push_back({out_src, out_data});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    idle(1);
    rst_n = 1'b1;
    got.delete();
  endtask

  task automatic check_seq(input string nm);
    check({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check(nm, got[i], exp[i]);
  endtask

  int ab_step, ab_cnt;

  initial begin
    @(negedge clk);
    idle(1);
    cmp_en = 1'b1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf0", s0_ovf, 0);
    rst_n = 1'b1;

    // Latency: 31 appears after the third edge following its strobe.
    step(1'b1, 8'h31, 1'b0, 8'h00);
    step(1'b1, 8'h0A, 1'b0, 8'h00);
    check("lat_not_yet", out_valid, 0);
    step(1'b0, 8'h00, 1'b0, 8'h00);
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 8'h31);
    check("lat_src", out_src, 0);
    idle(1);
    check("eof_data", out_data, 8'h0A);
    idle(1);
    check("eof_done", out_valid, 0);

    // Simultaneous frames: src0 first after reset.
    do_reset(); rec = 1'b1;
    step(1'b1, 8'h32, 1'b1, 8'h32);
    step(1'b1, 8'h0A, 1'b1, 8'h0A);
    idle(8);
    exp = '{9'h032, 9'h00A, 9'h132, 9'h10A};
    check_seq("rr_pair");
    // After a src0-only frame, round-robin favours src1; fixed priority does not.
    got.delete();
    step(1'b1, 8'h38, 1'b0, 8'h00);
    step(1'b1, 8'h0A, 1'b0, 8'h00);
    idle(6);
    got.delete();
    step(1'b1, 8'h39, 1'b1, 8'h3A);
    step(1'b1, 8'h0A, 1'b1, 8'h0A);
    idle(8);
`ifdef ARB_FIXED_PRIO_EN
    exp = '{9'h039, 9'h00A, 9'h13A, 9'h10A};
`else
    exp = '{9'h13A, 9'h10A, 9'h039, 9'h00A};
`endif
    check_seq("second_pair");

    // Overflow: 4 stored + 1 in output register, 6th byte dropped.
    do_reset(); rec = 1'b0; out_ready = 1'b0;
    step(1'b1, 8'h41, 1'b0, 8'h00);
    step(1'b1, 8'h42, 1'b0, 8'h00);
    step(1'b1, 8'h43, 1'b0, 8'h00);
    step(1'b1, 8'h44, 1'b0, 8'h00);
    step(1'b1, 8'h0A, 1'b0, 8'h00);
    check("ovf_none", s0_ovf, 0);
    check("ovf_hold", out_data, 8'h41);
    step(1'b1, 8'h45, 1'b0, 8'h00);
    check("ovf_set", s0_ovf, 1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("ovf_clr", s0_ovf, 0);
    rec = 1'b1; got.delete(); out_ready = 1'b1;
    idle(8);
    exp = '{9'h042, 9'h043, 9'h044, 9'h00A};
    check_seq("ovf_drain");

    // Locked source keeps the grant while the other waits.
    do_reset(); rec = 1'b1;
    step(1'b1, 8'h71, 1'b0, 8'h00);
    step(1'b1, 8'h72, 1'b1, 8'h33);
    step(1'b1, 8'h73, 1'b1, 8'h0A);
    step(1'b1, 8'h74, 1'b0, 8'h00);
    step(1'b1, 8'h0A, 1'b0, 8'h00);
    idle(8);
    exp = '{9'h071, 9'h072, 9'h073, 9'h074, 9'h00A, 9'h133, 9'h10A};
    check_seq("lock");

    // Timeout: src1 byte without EOF, abort 50 cycles after FIFO1 empties.
    do_reset(); rec = 1'b1; ab_step = 0; ab_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 1)      step(1'b0, 8'h00, 1'b1, 8'h34);
      else if (k == 5) step(1'b1, 8'h35, 1'b0, 8'h00);
      else if (k == 6) step(1'b1, 8'h0A, 1'b0, 8'h00);
      else             step(1'b0, 8'h00, 1'b0, 8'h00);
      if (out_abort) begin
        ab_cnt++;
        if (ab_step == 0) ab_step = k;
      end
    end
    check("to_step", ab_step, 53);
    check("to_pulses", ab_cnt, 1);
    exp = '{9'h134, 9'h035, 9'h00A};
    check_seq("to_seq");

    // Reset mid-frame discards everything.
    do_reset(); rec = 1'b0; out_ready = 1'b0;
    step(1'b1, 8'h51, 1'b0, 8'h00);
    step(1'b1, 8'h52, 1'b0, 8'h00);
    step(1'b1, 8'h53, 1'b0, 8'h00);
    check("mid_loaded", out_data, 8'h51);
    rst_n = 1'b0;
    idle(1);
    check("mid_valid", out_valid, 0);
    check("mid_data", out_data, 0);
    check("mid_src", out_src, 0);
    rst_n = 1'b1; out_ready = 1'b1; rec = 1'b1; got.delete();
    step(1'b0, 8'h00, 1'b1, 8'h61);
    step(1'b0, 8'h00, 1'b1, 8'h0A);
    idle(8);
    exp = '{9'h161, 9'h10A};
    check_seq("post_rst");

    // Random traffic against the model.
    rec = 1'b0;
    for (int blk = 0; blk < 8; blk++) begin
      int rdy_pct;
      rdy_pct = (blk % 3 == 0) ? 30 : 85;
      for (int c = 0; c < 250; c++) begin
        logic v0, v1;
        logic [7:0] d0, d1;
        v0 = ($urandom % 4) == 0;
        v1 = ($urandom % 4) == 0;
        d0 = (($urandom % 4) == 0) ? EOF : 8'($urandom);
        d1 = (($urandom % 4) == 0) ? EOF : 8'($urandom);
        out_ready = ($urandom % 100) < rdy_pct;
        ovf_clr = ($urandom % 16) == 0;
        step(v0, d0, v1, d1);
      end
    end
    ovf_clr = 1'b0; out_ready = 1'b1;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
